// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: one write port, two read ports and the
// clear/status signals. Clock and reset stay as plain module ports.
interface reg_file_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] IN;
  logic [ADDR_WIDTH-1:0] INADDRESS;
  logic                  WRITE;
  logic                  CLEAR;
  logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
  logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
  logic [DATA_WIDTH-1:0] OUT1;
  logic [DATA_WIDTH-1:0] OUT2;
  logic                  BUSY;
  logic                  WR_DROP;

  // Requester side: drives write/clear/read addresses, observes data and status.
  modport master (
    output IN, INADDRESS, WRITE, CLEAR, OUT1ADDRESS, OUT2ADDRESS,
    input  OUT1, OUT2, BUSY, WR_DROP
  );

  // Register file side.
  modport slave (
    input  IN, INADDRESS, WRITE, CLEAR, OUT1ADDRESS, OUT2ADDRESS,
    output OUT1, OUT2, BUSY, WR_DROP
  );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file with one write port, two combinational read
// ports, optional write-to-read forwarding and a clear sequencer that zeroes
// one entry per clock. Reset only starts the sweep; it never writes storage.
module reg_file_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int BYPASS     = 1
) (
  input  logic           CLK,
  input  logic           RESET,
  reg_file_param_if.slave bus
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam bit BYPASS_EN = (BYPASS != 0);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   ptr_reg, ptr_next;
  logic                    wr_drop_reg, wr_drop_next;

  // Flattened view of all entries so the read ports can index them.
  logic [DEPTH-1:0][DATA_WIDTH-1:0] entry_q;

  logic                    sweeping;
  logic [DATA_WIDTH-1:0]   rd1_next, rd2_next;

  assign sweeping = (state_reg == SWEEP);

  // Next-state logic for the clear sequencer and the dropped-write flag.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    wr_drop_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.CLEAR) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        // Writes are refused while sweeping; CLEAR here is simply ignored.
        wr_drop_next = bus.WRITE;
        if (ptr_reg == LAST_IDX) begin
          state_next = IDLE;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      default: begin
        state_next = SWEEP;
        ptr_next   = '0;
      end
    endcase
  end

  // Sequencer state register; reset (re)starts a full sweep from entry 0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= SWEEP;
      ptr_reg     <= '0;
      wr_drop_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      wr_drop_reg <= wr_drop_next;
    end
  end

  // One register per entry: the sweep owns the entry at PTR while sweeping,
  // otherwise a matching write updates it. A write coinciding with CLEAR in
  // IDLE lands here first and is zeroed later by the sweep.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);
    logic [DATA_WIDTH-1:0] entry_reg;

    // Entry update: sweep clear or normal write, nothing during reset.
    always_ff @(posedge CLK) begin
      if (!RESET) begin
        if (sweeping) begin
          if (ptr_reg == IDX) begin
            entry_reg <= '0;
          end
        end else if (bus.WRITE && (bus.INADDRESS == IDX)) begin
          entry_reg <= bus.IN;
        end
      end
    end

    assign entry_q[gi] = entry_reg;
  end

  // Read port 1: forced zero while sweeping, else forwarded or stored data.
  always_comb begin
    rd1_next = entry_q[bus.OUT1ADDRESS];
    if (sweeping) begin
      rd1_next = '0;
    end else if (BYPASS_EN && bus.WRITE && (bus.OUT1ADDRESS == bus.INADDRESS)) begin
      rd1_next = bus.IN;
    end
  end

  // Read port 2: identical behaviour, independent address.
  always_comb begin
    rd2_next = entry_q[bus.OUT2ADDRESS];
    if (sweeping) begin
      rd2_next = '0;
    end else if (BYPASS_EN && bus.WRITE && (bus.OUT2ADDRESS == bus.INADDRESS)) begin
      rd2_next = bus.IN;
    end
  end

  assign bus.OUT1    = rd1_next;
  assign bus.OUT2    = rd2_next;
  assign bus.BUSY    = sweeping;
  assign bus.WR_DROP = wr_drop_reg;

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, bit width of each register and data port.
REQ-002 Parameter: ADDR_WIDTH, default 3, address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 Parameter: BYPASS, default 1, 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset; sampled on rising CLK edge only.
REQ-006 IN  input  DATA_WIDTH  write data.
REQ-007 INADDRESS  input  ADDR_WIDTH  write address.
REQ-008 WRITE  input  1  write enable.
REQ-009 CLEAR  input  1  software request to zero all registers without RESET.
REQ-010 OUT1ADDRESS  input  ADDR_WIDTH  read port 1 address.
REQ-011 OUT2ADDRESS  input  ADDR_WIDTH  read port 2 address.
REQ-012 OUT1  output  DATA_WIDTH  read port 1 data.
REQ-013 OUT2  output  DATA_WIDTH  read port 2 data.
REQ-014 BUSY  output  1  high while clear sequencer is running.
REQ-015 WR_DROP  output  1  one-cycle pulse: a write was discarded.

Function
REQ-016 Storage SHALL be DEPTH x DATA_WIDTH; no entry is hardwired.
REQ-017 FSM SHALL have two states, IDLE and SWEEP, plus a clear pointer PTR of ADDR_WIDTH bits.
REQ-018 IDLE -> SWEEP, PTR <= 0, on an edge with CLEAR=1 and RESET=0.
REQ-019 In SWEEP on an edge with RESET=0: entry[PTR] <= 0; if PTR == DEPTH-1 go IDLE, else PTR <= PTR+1; a full sweep takes exactly DEPTH edges.
REQ-020 CLEAR while in SWEEP SHALL be ignored (no restart).
REQ-021 BUSY SHALL equal (state == SWEEP), registered, no combinational path from inputs.
REQ-022 In IDLE, an edge with WRITE=1 SHALL write IN to entry[INADDRESS]; data visible on read ports from that edge onward.
REQ-023 An edge with WRITE=1 and CLEAR=1 in IDLE SHALL perform the write, then start the sweep (the write is subsequently zeroed).
REQ-024 Edge with WRITE=1 while BUSY=1 and RESET=0: write discarded; WR_DROP = 1 for the following cycle, else 0.
REQ-025 Reads are combinational: OUTn = entry[OUTnADDRESS], both ports independent, same address on both allowed.
REQ-026 BYPASS=1, IDLE, WRITE=1, OUTnADDRESS == INADDRESS: OUTn SHALL equal IN combinationally in the same cycle (before the edge).
REQ-027 BYPASS=0: OUTn shows the old stored value until the edge.
REQ-028 While BUSY=1, OUT1 and OUT2 SHALL be forced to 0 regardless of address; no bypass.
REQ-029 No simulation delays in the RTL; all timing is cycle-based.

Reset
REQ-030 Edge with RESET=1: state <= SWEEP, PTR <= 0, WR_DROP <= 0; no array entry is written; WRITE and CLEAR are ignored.
REQ-031 After reset, BUSY = 1, OUT1 = OUT2 = 0, WR_DROP = 0; the first sweep write occurs on the first edge with RESET=0.
REQ-032 RESET during SWEEP SHALL restart the sweep at PTR=0; RESET held N cycles delays completion by N cycles.
REQ-033 Reads never return X after the sweep completes.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3)
REQ-034 RESET high for 1 edge, then low -> BUSY=1 for exactly 8 edges after RESET deasserts, then 0; all 8 entries read 8'h00.
REQ-035 IDLE, WRITE=1, IN=8'h1F, INADDRESS=2, OUT1ADDRESS=2, BYPASS=1 -> OUT1=8'h1F before the edge, still 8'h1F after with WRITE=0; repeat with BYPASS=0 -> OUT1 old value until edge.
REQ-036 WRITE=1, IN=8'h55 on the 3rd sweep edge -> write dropped, WR_DROP=1 for one cycle, after sweep entry reads 8'h00.
REQ-037 Write 8'hFF to all entries, pulse CLEAR, assert CLEAR again mid-sweep -> sweep still completes in 8 edges; all entries 8'h00.
REQ-038 RESET asserted at PTR=5 during a sweep -> PTR restarts at 0; BUSY stays high 8 edges after RESET deasserts.
REQ-039 Edge with WRITE=1, IN=8'hA5, INADDRESS=7, CLEAR=1 -> BUSY=1 next cycle; after sweep entry 7 reads 8'h00.
